// File: rtl/alu_pipe_if.sv
// ============================================================================
// alu_pipe_if : operand/result handshake bundle for alu_pipe
// Rev 1.0
// ============================================================================
`default_nettype none

interface alu_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       opcode;
  logic             sat;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             zero;
  logic             carry;
  logic             negative;
  logic             overflow;

  modport master (
    output in_valid, a, b, opcode, sat, out_ready,
    input  in_ready, out_valid, out, zero, carry, negative, overflow
  );

  modport slave (
    input  in_valid, a, b, opcode, sat, out_ready,
    output in_ready, out_valid, out, zero, carry, negative, overflow
  );
endinterface

`default_nettype wire

// File: rtl/alu_pipe.sv
// ============================================================================
// alu_pipe : two-stage WIDTH-bit ALU with valid/ready and optional saturation
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_pipe #(
  parameter int WIDTH  = 8,
  parameter int SAT_EN = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_pipe_if.slave   bus
);

  localparam logic [2:0] c_op_add = 3'd0;
  localparam logic [2:0] c_op_sub = 3'd1;
  localparam logic [2:0] c_op_or  = 3'd2;
  localparam logic [2:0] c_op_and = 3'd3;
  localparam logic [2:0] c_op_xor = 3'd4;
  localparam logic [2:0] c_op_sll = 3'd5;
  localparam logic [2:0] c_op_srl = 3'd6;
  localparam logic [2:0] c_op_slt = 3'd7;

  localparam int               c_msb   = WIDTH - 1;
  localparam logic [WIDTH-1:0] c_width = WIDTH'(WIDTH);
  localparam logic [WIDTH-1:0] c_smax  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] c_smin  = {1'b1, {(WIDTH-1){1'b0}}};

  // Stage 1: captured operands
  logic             r_s1_valid;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_op;
  logic             r_sat;

  // Stage 2: registered result and flags
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_out;
  logic             r_zero;
  logic             r_carry;
  logic             r_negative;
  logic             r_overflow;

  logic             w_s1_adv;
  logic             w_s2_adv;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic             w_shift_oor;
  logic             w_lt;
  logic             w_sat_allow;
  logic [WIDTH-1:0] w_res;
  logic             w_carry;
  logic             w_ovf;
  logic [WIDTH-1:0] w_final;

  assign w_s2_adv = !r_s2_valid || bus.out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;

  assign w_sum       = {1'b0, r_a} + {1'b0, r_b};
  // The extra top bit of the difference is the borrow, i.e. unsigned a < b.
  assign w_diff      = {1'b0, r_a} - {1'b0, r_b};
  assign w_shift_oor = (r_b >= c_width);
  assign w_lt        = ($signed(r_a) < $signed(r_b));
  assign w_sat_allow = r_sat && (SAT_EN != 0);

  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (r_op)
      c_op_add: begin
        w_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
        w_ovf   = (r_a[c_msb] == r_b[c_msb]) && (w_sum[c_msb] != r_a[c_msb]);
      end
      c_op_sub: begin
        w_res   = w_diff[WIDTH-1:0];
        w_carry = w_diff[WIDTH];
        w_ovf   = (r_a[c_msb] != r_b[c_msb]) && (w_diff[c_msb] != r_a[c_msb]);
      end
      c_op_or:  w_res = r_a | r_b;
      c_op_and: w_res = r_a & r_b;
      c_op_xor: w_res = r_a ^ r_b;
      c_op_sll: w_res = w_shift_oor ? '0 : (r_a << r_b);
      c_op_srl: w_res = w_shift_oor ? '0 : (r_a >> r_b);
      c_op_slt: w_res = {{(WIDTH-1){1'b0}}, w_lt};
      default:  w_res = '0;
    endcase
  end

  // On ADD/SUB overflow the true result always carries the sign of operand a.
  assign w_final = (w_ovf && w_sat_allow) ? (r_a[c_msb] ? c_smin : c_smax) : w_res;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_op       <= 3'd0;
      r_sat      <= 1'b0;
    end else if (w_s1_adv) begin
      r_s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_a   <= bus.a;
        r_b   <= bus.b;
        r_op  <= bus.opcode;
        r_sat <= bus.sat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_out      <= '0;
      r_zero     <= 1'b0;
      r_carry    <= 1'b0;
      r_negative <= 1'b0;
      r_overflow <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out      <= w_final;
        r_zero     <= (w_final == '0);
        r_carry    <= w_carry;
        r_negative <= w_final[c_msb];
        r_overflow <= w_ovf;
      end
    end
  end

  assign bus.in_ready  = !rst_n || w_s1_adv;
  assign bus.out_valid = r_s2_valid;
  assign bus.out       = r_out;
  assign bus.zero      = r_zero;
  assign bus.carry     = r_carry;
  assign bus.negative  = r_negative;
  assign bus.overflow  = r_overflow;

endmodule

`default_nettype wire
